// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/sequencing controller for the 5-stage MIPS pipeline.
// Decides per cycle whether each pipeline register advances, holds or takes
// a bubble, and keeps stall/flush statistics plus a sticky dmem timeout flag.
module pipeline_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rd,
   input  logic        ex_branch_taken,
   input  logic        ex_jump,
   input  logic        mem_req,
   input  logic        dmem_ready,
   input  logic        imem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic [1:0]  ctrl_state,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic        mem_timeout
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WIDE_W = CNT_W + 1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [WIDE_W-1:0] TIMEOUT_W = WIDE_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FREEZE   = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_STALL    = 2'd3
   } state_e;

   state_e             state_d, state_q;
   logic [CNT_W-1:0]   stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0]   flush_cnt_d, flush_cnt_q;
   logic [CNT_W-1:0]   wait_cnt_d, wait_cnt_q;
   logic               mem_timeout_d, mem_timeout_q;

   logic               freeze;
   logic               redirect;
   logic               load_use;
   logic               fetch_wait;
   logic               rd_hits_rs;
   logic               rd_hits_rt;
   logic [WIDE_W-1:0]  wait_next_wide;

   // Raw hazard conditions from the current cycle's inputs.
   always_comb begin
      freeze     = mem_req && !dmem_ready;
      redirect   = ex_branch_taken || ex_jump;
      rd_hits_rs = (ex_rd == id_rs);
      rd_hits_rt = id_uses_rt && (ex_rd == id_rt);
      load_use   = id_valid && ex_memread && (ex_rd != 5'd0) &&
                   (rd_hits_rs || rd_hits_rt);
      fetch_wait = !imem_ready;
   end

   // Priority resolution: freeze > redirect > load-use > fetch wait > run.
   always_comb begin
      state_d    = ST_RUN;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;

      if (freeze) begin
         state_d  = ST_FREEZE;
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (redirect) begin
         state_d    = ST_REDIRECT;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         // Hold PC and IF/ID, inject a bubble into EX.
         state_d    = ST_STALL;
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (fetch_wait) begin
         // No valid fetch word: keep PC, feed a bubble into ID; reported as RUN.
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end

      // Nothing moves while reset is held.
      if (!rst_n) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_en    = 1'b0;
         exmem_en   = 1'b0;
         memwb_en   = 1'b0;
         ifid_flush = 1'b0;
         idex_flush = 1'b0;
      end
   end

   // Saturating statistics and the freeze watchdog.
   always_comb begin
      stall_cnt_d    = stall_cnt_q;
      flush_cnt_d    = flush_cnt_q;
      wait_cnt_d     = '0;
      mem_timeout_d  = mem_timeout_q;
      wait_next_wide = WIDE_W'(wait_cnt_q) + WIDE_W'(1);

      if ((state_d == ST_STALL) && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if ((state_d == ST_REDIRECT) && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      if (state_d == ST_FREEZE) begin
         wait_cnt_d = (wait_cnt_q == CNT_MAX) ? CNT_MAX : wait_cnt_q + CNT_W'(1);
         if (wait_next_wide >= TIMEOUT_W) begin
            mem_timeout_d = 1'b1;
         end
      end
   end

   // State and statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // Registered status outputs.
   always_comb begin
      ctrl_state  = state_q;
      stall_cnt   = stall_cnt_q;
      flush_cnt   = flush_cnt_q;
      mem_timeout = mem_timeout_q;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage MIPS pipeline. Each cycle it decides whether each pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) advances, holds or is loaded with a bubble. It resolves four conditions by priority: data-memory wait, taken branch/jump redirect, load-use hazard and instruction-fetch wait. It also keeps saturating stall and flush statistics and a sticky data-memory timeout flag.

## Interface
- TIMEOUT, 255: consecutive freeze cycles after which mem_timeout sets; legal range 1..65535.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs  in  5  rs field of the instruction in ID (bits 25:21).
- id_rt  in  5  rt field of the instruction in ID (bits 20:16).
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch).
- ex_memread  in  1  MemRead of the instruction in EX.
- ex_rd  in  5  destination register of EX, after RegDst mux.
- ex_branch_taken  in  1  branch in EX resolved taken.
- ex_jump  in  1  jump in EX.
- mem_req  in  1  MEM stage performs a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- imem_ready  in  1  instruction memory delivers a valid word this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush  out  1 each  load a bubble (all controls 0) instead of data.
- ctrl_state  out  2  action taken in the previous cycle: 0 RUN, 1 FREEZE, 2 REDIRECT, 3 STALL.
- stall_cnt  out  16  saturating count of load-use stall cycles.
- flush_cnt  out  16  saturating count of redirect cycles.
- mem_timeout  out  1  sticky; consecutive freezes reached TIMEOUT.

## Operation
- Rules are evaluated combinationally each cycle in strict priority order. The first match wins.
- FREEZE (mem_req && !dmem_ready):
  - All five enables 0; both flushes 0.
  - Redirect and load-use are not acted on. They are re-evaluated when the freeze ends, because pipeline contents are unchanged.
- REDIRECT (ex_branch_taken || ex_jump):
  - All enables 1; ifid_flush=1, idex_flush=1.
  - The PC loads the target; the two younger instructions are squashed.
  - flush_cnt increments.
- STALL, load-use: requires all of
  - id_valid && ex_memread && ex_rd != 0
  - and (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt)).
  - Response: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=1, memwb_en=1.
  - stall_cnt increments.
- FETCH WAIT (!imem_ready):
  - pc_en=0, ifid_en=1 with ifid_flush=1; all other enables 1.
  - Reported as RUN in ctrl_state; no counter change.
- RUN otherwise: all enables 1, flushes 0.
- A register 0 destination never causes a stall. ex_rd is compared with full 5-bit equality.
- Counters saturate at 16'hFFFF and never wrap.
- Freeze watchdog (wait_cnt, 16 bits, internal):
  - Increments on every FREEZE cycle; clears to 0 on any non-FREEZE cycle.
  - When wait_cnt+1 reaches TIMEOUT, mem_timeout sets and stays 1 until reset.
  - wait_cnt itself saturates.

## Timing
- Enables and flushes are purely combinational from current inputs, in the same cycle. Pipeline registers sample them at the next rising clk.
- ctrl_state, stall_cnt, flush_cnt, wait_cnt and mem_timeout are registered and update at the rising edge that closes the cycle.
- Load-use costs exactly 1 bubble cycle: the next cycle sees ex_memread=0 because a bubble is now in EX.
- Redirect costs 2 squashed instructions.
- Reset (rst_n low, asynchronous):
  - ctrl_state=0, stall_cnt=0, flush_cnt=0, wait_cnt=0, mem_timeout=0.
  - While rst_n is low, all enables are forced 0 and both flushes 0.
  - Reset asserted mid-freeze or mid-stall abandons the operation immediately.
- Simultaneous events:
  - freeze+redirect: freeze wins; the redirect applies on the first cycle with dmem_ready=1.
  - redirect+load-use: redirect wins; the stall is dropped because ID is squashed.
  - load-use+fetch wait: the stall wins; ifid_flush stays 0 so the ID instruction is held.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs, then release.
  - During reset: all enables 0, both flushes 0.
  - After release: counters 0, ctrl_state=0.
- Load-use: ex_memread=1, ex_rd=8, id_rs=8, id_valid=1 for 1 cycle.
  - That cycle: pc_en=0, ifid_en=0, idex_flush=1.
  - Next edge: ctrl_state=3, stall_cnt=1.
  - Repeat with ex_rd=0: no stall.
  - Repeat with ex_rd=9, id_rt=9, id_uses_rt=0: no stall.
- Redirect over load-use: ex_branch_taken=1 plus a load-use match.
  - Response: all enables 1, ifid_flush=idex_flush=1, flush_cnt=1, stall_cnt unchanged.
- Freeze with pending jump: mem_req=1, dmem_ready=0 for 4 cycles with ex_jump=1.
  - During the 4 cycles: enables 0, no flush.
  - Cycle 5, dmem_ready=1: redirect, flush_cnt +1.
- Timeout: TIMEOUT=4, freeze for 4 cycles.
  - mem_timeout=1 after the 4th edge.
  - After dmem_ready=1: mem_timeout stays 1 until rst_n pulses low.
- Saturation: force 65540 load-use cycles.
  - stall_cnt ends at 16'hFFFF and never returns to 0.
